// File: rtl/dual_issue_scheduler.sv
// Dual-lane issue controller: splits conflicting pairs and stalls on load-use hazards.
// Optional SCHED_PERF_EN adds saturating split/stall performance counters.
module dual_issue_scheduler #(
    parameter int REG_ADDR_WIDTH = 5
`ifdef SCHED_PERF_EN
    ,
    parameter int PERF_CNT_WIDTH = 32
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_d_0,
    input  logic                      valid_d_1,
    input  logic [REG_ADDR_WIDTH-1:0] rs_d_0,
    input  logic [REG_ADDR_WIDTH-1:0] rt_d_0,
    input  logic [REG_ADDR_WIDTH-1:0] rs_d_1,
    input  logic [REG_ADDR_WIDTH-1:0] rt_d_1,
    input  logic [REG_ADDR_WIDTH-1:0] dest_d_0,
    input  logic                      regwrite_d_0,
    input  logic                      mem_d_0,
    input  logic                      mem_d_1,
    input  logic                      startmult_d_0,
    input  logic                      startmult_d_1,
    input  logic                      memread_e_0,
    input  logic                      memread_e_1,
    input  logic [REG_ADDR_WIDTH-1:0] writeReg_e_0,
    input  logic [REG_ADDR_WIDTH-1:0] writeReg_e_1,
    input  logic                      flush_d,
    output logic                      issue_0,
    output logic                      issue_1,
    output logic                      stall_fd,
    output logic                      split_pending
`ifdef SCHED_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_split_cnt,
    output logic [PERF_CNT_WIDTH-1:0] perf_stall_cnt
`endif
);

    typedef enum logic [0:0] {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   lu_0_s;
    logic   lu_1_s;
    logic   raw_s;
    logic   conflict_s;

    // Register 0 is hardwired, so it never matches anything.
    function automatic logic spec_match(
        input logic [REG_ADDR_WIDTH-1:0] a,
        input logic [REG_ADDR_WIDTH-1:0] b
    );
        return (a != {REG_ADDR_WIDTH{1'b0}}) && (a == b);
    endfunction

    function automatic logic load_hit(
        input logic [REG_ADDR_WIDTH-1:0] src,
        input logic                      rd_0,
        input logic [REG_ADDR_WIDTH-1:0] wr_0,
        input logic                      rd_1,
        input logic [REG_ADDR_WIDTH-1:0] wr_1
    );
        return (rd_0 && spec_match(src, wr_0)) || (rd_1 && spec_match(src, wr_1));
    endfunction

    assign lu_0_s = valid_d_0 &&
        (load_hit(rs_d_0, memread_e_0, writeReg_e_0, memread_e_1, writeReg_e_1) ||
         load_hit(rt_d_0, memread_e_0, writeReg_e_0, memread_e_1, writeReg_e_1));
    assign lu_1_s = valid_d_1 &&
        (load_hit(rs_d_1, memread_e_0, writeReg_e_0, memread_e_1, writeReg_e_1) ||
         load_hit(rt_d_1, memread_e_0, writeReg_e_0, memread_e_1, writeReg_e_1));
    assign raw_s = regwrite_d_0 && (spec_match(dest_d_0, rs_d_1) || spec_match(dest_d_0, rt_d_1));
    assign conflict_s = valid_d_0 && valid_d_1 &&
        (raw_s || (mem_d_0 && mem_d_1) || (startmult_d_0 && startmult_d_1));

    // Issue decision and next state; reset and flush override everything.
    always_comb begin
        issue_0     = 1'b0;
        issue_1     = 1'b0;
        stall_fd    = 1'b0;
        state_nxt_s = state_r;
        if (reset || flush_d) begin
            state_nxt_s = PAIR;
        end else begin
            case (state_r)
                PAIR: begin
                    if (lu_0_s) begin
                        stall_fd = 1'b1;
                    end else if (!valid_d_0) begin
                        issue_1  = valid_d_1 && !lu_1_s;
                        stall_fd = lu_1_s;
                    end else if (conflict_s || lu_1_s) begin
                        issue_0     = 1'b1;
                        stall_fd    = 1'b1;
                        state_nxt_s = SECOND;
                    end else begin
                        issue_0 = 1'b1;
                        issue_1 = valid_d_1;
                    end
                end
                SECOND: begin
                    if (lu_1_s) begin
                        stall_fd = 1'b1;
                    end else begin
                        issue_1     = 1'b1;
                        state_nxt_s = PAIR;
                    end
                end
                default: begin
                    state_nxt_s = PAIR;
                end
            endcase
        end
    end

    assign split_pending = (state_r == SECOND) && !reset;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= PAIR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

`ifdef SCHED_PERF_EN
    logic split_evt_s;
    logic stall_evt_s;

    assign split_evt_s = (state_r == PAIR) && (state_nxt_s == SECOND);
    assign stall_evt_s = stall_fd && !flush_d;

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_split_cnt <= {PERF_CNT_WIDTH{1'b0}};
            perf_stall_cnt <= {PERF_CNT_WIDTH{1'b0}};
        end else begin
            if (split_evt_s && (perf_split_cnt != {PERF_CNT_WIDTH{1'b1}})) begin
                perf_split_cnt <= perf_split_cnt + {{(PERF_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                perf_split_cnt <= perf_split_cnt;
            end
            if (stall_evt_s && (perf_stall_cnt != {PERF_CNT_WIDTH{1'b1}})) begin
                perf_stall_cnt <= perf_stall_cnt + {{(PERF_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: directed scenarios plus randomized
// traffic against a behavioural issue model. Define SCHED_PERF_EN to cover the counters.
module tb_dual_issue_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_d_0, valid_d_1;
    logic [4:0] rs_d_0, rt_d_0, rs_d_1, rt_d_1, dest_d_0;
    logic       regwrite_d_0, mem_d_0, mem_d_1, startmult_d_0, startmult_d_1;
    logic       memread_e_0, memread_e_1;
    logic [4:0] writeReg_e_0, writeReg_e_1;
    logic       flush_d;
    logic       issue_0, issue_1, stall_fd, split_pending;
`ifdef SCHED_PERF_EN
    logic [31:0] perf_split_cnt, perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [3:0] obs;
    assign obs = {issue_0, issue_1, stall_fd, split_pending};

    dual_issue_scheduler dut (
        .clk(clk), .reset(reset),
        .valid_d_0(valid_d_0), .valid_d_1(valid_d_1),
        .rs_d_0(rs_d_0), .rt_d_0(rt_d_0), .rs_d_1(rs_d_1), .rt_d_1(rt_d_1),
        .dest_d_0(dest_d_0), .regwrite_d_0(regwrite_d_0),
        .mem_d_0(mem_d_0), .mem_d_1(mem_d_1),
        .startmult_d_0(startmult_d_0), .startmult_d_1(startmult_d_1),
        .memread_e_0(memread_e_0), .memread_e_1(memread_e_1),
        .writeReg_e_0(writeReg_e_0), .writeReg_e_1(writeReg_e_1),
        .flush_d(flush_d),
        .issue_0(issue_0), .issue_1(issue_1), .stall_fd(stall_fd),
        .split_pending(split_pending)
`ifdef SCHED_PERF_EN
        ,
        .perf_split_cnt(perf_split_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        valid_d_0 = 1'b0; valid_d_1 = 1'b0;
        rs_d_0 = 5'd0; rt_d_0 = 5'd0; rs_d_1 = 5'd0; rt_d_1 = 5'd0; dest_d_0 = 5'd0;
        regwrite_d_0 = 1'b0; mem_d_0 = 1'b0; mem_d_1 = 1'b0;
        startmult_d_0 = 1'b0; startmult_d_1 = 1'b0;
        memread_e_0 = 1'b0; memread_e_1 = 1'b0;
        writeReg_e_0 = 5'd0; writeReg_e_1 = 5'd0;
        flush_d = 1'b0;
    endtask

    // Independent pair: lane 1 reads 3/4, lane 0 writes 5.
    task automatic set_indep_pair();
        set_idle();
        valid_d_0 = 1'b1; valid_d_1 = 1'b1;
        rs_d_0 = 5'd1; rt_d_0 = 5'd2; rs_d_1 = 5'd3; rt_d_1 = 5'd4;
        dest_d_0 = 5'd5; regwrite_d_0 = 1'b1;
    endtask

    task automatic pulse_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Behavioural reference: expected {issue_0, issue_1, stall_fd, split_pending}.
    task automatic model(input bit pend, output logic [3:0] exp, output bit npend);
        logic [4:0] src [2][2];
        logic [4:0] ld  [$];
        bit         v   [2];
        bit         blk [2];
        bit         conf;
        src[0][0] = rs_d_0; src[0][1] = rt_d_0; src[1][0] = rs_d_1; src[1][1] = rt_d_1;
        v[0] = valid_d_0; v[1] = valid_d_1;
        if (memread_e_0 && writeReg_e_0 != 5'd0) ld.push_back(writeReg_e_0);
        if (memread_e_1 && writeReg_e_1 != 5'd0) ld.push_back(writeReg_e_1);
        for (int k = 0; k < 2; k++) begin
            blk[k] = 1'b0;
            for (int s = 0; s < 2; s++)
                foreach (ld[j]) if (v[k] && src[k][s] == ld[j]) blk[k] = 1'b1;
        end
        conf = v[0] && v[1] &&
               ((regwrite_d_0 && dest_d_0 != 5'd0 && (dest_d_0 == rs_d_1 || dest_d_0 == rt_d_1)) ||
                (mem_d_0 && mem_d_1) || (startmult_d_0 && startmult_d_1));
        npend = 1'b0;
        if (flush_d) exp = {3'b000, pend};
        else if (pend) begin
            exp   = blk[1] ? 4'b0011 : 4'b0101;
            npend = blk[1];
        end else if (blk[0]) exp = 4'b0010;
        else if (!v[0]) exp = {1'b0, v[1] && !blk[1], blk[1], 1'b0};
        else if (conf || blk[1]) begin
            exp   = 4'b1010;
            npend = 1'b1;
        end else exp = {1'b1, v[1], 2'b00};
    endtask

    task automatic test_reset();
        set_indep_pair();
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 4'b0000) begin
            $display("FAIL reset_outputs: got %b want 0000", obs);
            bad++;
        end
        @(posedge clk); #1;
        total++;
        if (obs !== 4'b0000) begin
            $display("FAIL reset_after_edge: got %b want 0000", obs);
            bad++;
        end
        reset = 1'b0;
        set_idle();
        tick();
    endtask

    task automatic test_independent();
        set_indep_pair();
        @(negedge clk);
        total++;
        if (obs !== 4'b1100) begin
            $display("FAIL indep_pair: got %b want 1100", obs);
            bad++;
        end
        tick();
        total++;
        if (split_pending !== 1'b0) begin
            $display("FAIL indep_state: got split_pending=%b want 0", split_pending);
            bad++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_raw();
        set_indep_pair();
        dest_d_0 = 5'd7; rs_d_1 = 5'd7;
        @(negedge clk);
        total++;
        if (obs !== 4'b1010) begin
            $display("FAIL raw_cycle0: got %b want 1010", obs);
            bad++;
        end
        tick();
        @(negedge clk);
        total++;
        if (obs !== 4'b0101) begin
            $display("FAIL raw_cycle1: got %b want 0101", obs);
            bad++;
        end
        tick();
        dest_d_0 = 5'd0; rs_d_1 = 5'd0;
        @(negedge clk);
        total++;
        if (obs !== 4'b1100) begin
            $display("FAIL raw_dest_zero: got %b want 1100", obs);
            bad++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        set_indep_pair();
        memread_e_1 = 1'b1; writeReg_e_1 = 5'd9; rt_d_0 = 5'd9;
        @(negedge clk);
        total++;
        if (obs !== 4'b0010) begin
            $display("FAIL load_use_stall: got %b want 0010", obs);
            bad++;
        end
        tick();
        memread_e_1 = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 4'b1100) begin
            $display("FAIL load_use_release: got %b want 1100", obs);
            bad++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_resource();
        for (int r = 0; r < 2; r++) begin
            set_indep_pair();
            if (r == 0) begin mem_d_0 = 1'b1; mem_d_1 = 1'b1; end
            else begin startmult_d_0 = 1'b1; startmult_d_1 = 1'b1; end
            @(negedge clk);
            total++;
            if (obs !== 4'b1010) begin
                $display("FAIL resource%0d_cycle0: got %b want 1010", r, obs);
                bad++;
            end
            tick();
            @(negedge clk);
            total++;
            if (obs !== 4'b0101) begin
                $display("FAIL resource%0d_cycle1: got %b want 0101", r, obs);
                bad++;
            end
            set_idle();
            tick();
        end
    endtask

    task automatic test_flush_second();
        set_indep_pair();
        mem_d_0 = 1'b1; mem_d_1 = 1'b1;
        tick();
        flush_d = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 4'b0001) begin
            $display("FAIL flush_in_second: got %b want 0001", obs);
            bad++;
        end
        tick();
        set_idle();
        @(negedge clk);
        total++;
        if (obs !== 4'b0000) begin
            $display("FAIL flush_next: got %b want 0000", obs);
            bad++;
        end
        tick();
    endtask

    task automatic test_async_reset();
        set_indep_pair();
        mem_d_0 = 1'b1; mem_d_1 = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (obs !== 4'b0101) begin
            $display("FAIL async_pre_second: got %b want 0101", obs);
            bad++;
        end
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 4'b0000) begin
            $display("FAIL async_reset_outputs: got %b want 0000", obs);
            bad++;
        end
        reset = 1'b0;
        #1;
        total++;
        if (obs !== 4'b1010) begin
            $display("FAIL async_reset_dropped: got %b want 1010", obs);
            bad++;
        end
        set_idle();
        tick();
    endtask

`ifdef SCHED_PERF_EN
    task automatic test_perf();
        pulse_reset();
        total++;
        if (perf_split_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            $display("FAIL perf_reset: got split=%0d stall=%0d want 0 0", perf_split_cnt, perf_stall_cnt);
            bad++;
        end
        for (int n = 0; n < 2; n++) begin
            set_indep_pair();
            mem_d_0 = 1'b1; mem_d_1 = 1'b1;
            tick();
            tick();
        end
        set_idle();
        total++;
        if (perf_split_cnt !== 32'd2 || perf_stall_cnt !== 32'd2) begin
            $display("FAIL perf_counts: got split=%0d stall=%0d want 2 2", perf_split_cnt, perf_stall_cnt);
            bad++;
        end
        tick();
    endtask
`endif

    task automatic test_random();
        bit         pend = 1'b0;
        bit         npend;
        bit         hold = 1'b0;
        logic [3:0] exp;
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                valid_d_0 = ($urandom_range(3, 0) != 0);
                valid_d_1 = ($urandom_range(3, 0) != 0);
                rs_d_0 = 5'($urandom_range(7, 0)); rt_d_0 = 5'($urandom_range(7, 0));
                rs_d_1 = 5'($urandom_range(7, 0)); rt_d_1 = 5'($urandom_range(7, 0));
                dest_d_0 = 5'($urandom_range(7, 0));
                regwrite_d_0 = 1'($urandom_range(1, 0));
                mem_d_0 = ($urandom_range(2, 0) == 0); mem_d_1 = ($urandom_range(2, 0) == 0);
                startmult_d_0 = ($urandom_range(3, 0) == 0);
                startmult_d_1 = ($urandom_range(3, 0) == 0);
            end
            memread_e_0 = ($urandom_range(2, 0) == 0);
            memread_e_1 = ($urandom_range(2, 0) == 0);
            writeReg_e_0 = 5'($urandom_range(7, 0));
            writeReg_e_1 = 5'($urandom_range(7, 0));
            flush_d = ($urandom_range(15, 0) == 0);
            model(pend, exp, npend);
            @(negedge clk);
            total++;
            if (obs !== exp) begin
                $display("FAIL random_c%0d: got %b want %b", c, obs, exp);
                bad++;
            end
            hold = exp[1] && !flush_d;
            pend = npend;
            tick();
        end
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        test_reset();
        test_independent();
        test_raw();
        test_load_use();
        test_resource();
        test_flush_second();
        test_async_reset();
`ifdef SCHED_PERF_EN
        test_perf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
